// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR job sequencer: ap_ctrl handshake, buffer clear, BRAM addressing, MAC control
module fir_seq_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ap_start_set,
  input  logic                  ctrl_read_ack,
  input  logic [DATA_WIDTH-1:0] data_length,
  output logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic                  ss_tvalid,
  input  logic                  ss_tlast,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  input  logic                  sm_tready,
  output logic                  sm_tlast,
  output logic [ADDR_WIDTH-1:0] tap_a,
  output logic                  data_en,
  output logic [3:0]            data_we,
  output logic [ADDR_WIDTH-1:0] data_a,
  output logic                  data_di_sel,
  output logic                  mac_clr,
  output logic                  mac_en
);

  localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TAPS - 1);
  localparam logic [IW-1:0] NT_W     = IW'(NUM_TAPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT_IN,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         head, head_nx;
  logic [DATA_WIDTH-1:0] len, len_nx;
  logic [DATA_WIDTH-1:0] out_cnt, out_cnt_nx;
  logic                  tlast_seen, tlast_seen_nx;
  logic                  ap_start_nx, ap_done_nx;
  logic                  is_last;
  logic [IW-1:0]         rd_idx;

  // Word index -> BRAM byte address
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] idx);
    word_addr = ADDR_WIDTH'(idx) << 2;
  endfunction

  // Circular read pointer (head - k) mod NUM_TAPS without ever exceeding IW bits
  assign rd_idx  = (head >= cnt) ? (head - cnt) : (NT_W - (cnt - head));
  assign is_last = (out_cnt == (len - DATA_WIDTH'(1))) || tlast_seen;

  // State and job bookkeeping registers
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      head       <= '0;
      len        <= '0;
      out_cnt    <= '0;
      tlast_seen <= 1'b0;
      ap_start   <= 1'b0;
      ap_done    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      head       <= head_nx;
      len        <= len_nx;
      out_cnt    <= out_cnt_nx;
      tlast_seen <= tlast_seen_nx;
      ap_start   <= ap_start_nx;
      ap_done    <= ap_done_nx;
    end
  end

  // Next-state logic and state-decoded BRAM/MAC/stream controls
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    head_nx       = head;
    len_nx        = len;
    out_cnt_nx    = out_cnt;
    tlast_seen_nx = tlast_seen;
    ap_start_nx   = ap_start;
    ap_done_nx    = ctrl_read_ack ? 1'b0 : ap_done;
    ap_idle       = (state == S_IDLE) || (state == S_DONE);
    ss_tready     = 1'b0;
    sm_tvalid     = 1'b0;
    sm_tlast      = 1'b0;
    tap_a         = '0;
    data_en       = (state != S_IDLE);
    data_we       = 4'h0;
    data_a        = '0;
    data_di_sel   = 1'b0;
    mac_clr       = 1'b0;
    mac_en        = 1'b0;

    case (state)
      S_IDLE: begin
        if (ap_start_set) begin
          ap_start_nx   = 1'b1;
          ap_done_nx    = 1'b0;
          len_nx        = data_length;
          cnt_nx        = '0;
          head_nx       = '0;
          out_cnt_nx    = '0;
          tlast_seen_nx = 1'b0;
          state_nx      = S_CLR;
        end
      end

      S_CLR: begin
        data_we     = 4'hF;
        data_a      = word_addr(cnt);
        data_di_sel = 1'b0;
        if (cnt == LAST_IDX) begin
          cnt_nx = '0;
          if (len == '0) begin
            ap_done_nx = 1'b1;
            state_nx   = S_DONE;
          end else begin
            state_nx = S_WAIT_IN;
          end
        end else begin
          cnt_nx = cnt + IW'(1);
        end
      end

      S_WAIT_IN: begin
        ss_tready   = 1'b1;
        data_a      = word_addr(head);
        data_di_sel = 1'b1;
        if (ss_tvalid) begin
          data_we       = 4'hF;
          mac_clr       = 1'b1;
          ap_start_nx   = 1'b0;
          tlast_seen_nx = ss_tlast;
          cnt_nx        = '0;
          state_nx      = S_MAC;
        end
      end

      S_MAC: begin
        tap_a  = word_addr(cnt);
        data_a = word_addr(rd_idx);
        mac_en = (cnt != '0);
        if (cnt == LAST_IDX) begin
          cnt_nx   = '0;
          state_nx = S_DRAIN;
        end else begin
          cnt_nx = cnt + IW'(1);
        end
      end

      S_DRAIN: begin
        mac_en   = 1'b1;
        state_nx = S_OUT;
      end

      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = is_last;
        if (sm_tready) begin
          out_cnt_nx = out_cnt + DATA_WIDTH'(1);
          head_nx    = (head == LAST_IDX) ? '0 : head + IW'(1);
          if (is_last) begin
            ap_done_nx = 1'b1;
            state_nx   = S_DONE;
          end else begin
            state_nx = S_WAIT_IN;
          end
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - randomized job-level reference-model bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

  localparam int NT = 11;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        ap_start_set = 1'b0;
  logic        ctrl_read_ack = 1'b0;
  logic [31:0] data_length = '0;
  logic        ap_start, ap_done, ap_idle;
  logic        ss_tvalid = 1'b0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic        sm_tvalid, sm_tlast;
  logic        sm_tready = 1'b0;
  logic [11:0] tap_a, data_a;
  logic        data_en, data_di_sel, mac_clr, mac_en;
  logic [3:0]  data_we;
  logic [31:0] ss_tdata = '0;

  fir_seq_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_TAPS(NT)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ap_start_set(ap_start_set), .ctrl_read_ack(ctrl_read_ack),
    .data_length(data_length), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_a(tap_a), .data_en(data_en), .data_we(data_we), .data_a(data_a),
    .data_di_sel(data_di_sel), .mac_clr(mac_clr), .mac_en(mac_en)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ap_idle"}, ap_idle, 1);
    chk({p, "_ap_start"}, ap_start, 0);
    chk({p, "_ap_done"}, ap_done, 0);
    chk({p, "_ss_tready"}, ss_tready, 0);
    chk({p, "_sm_tvalid"}, sm_tvalid, 0);
    chk({p, "_sm_tlast"}, sm_tlast, 0);
    chk({p, "_data_we"}, data_we, 0);
    chk({p, "_data_en"}, data_en, 0);
    chk({p, "_mac_clr"}, mac_clr, 0);
    chk({p, "_mac_en"}, mac_en, 0);
    chk({p, "_tap_a"}, tap_a, 0);
    chk({p, "_data_a"}, data_a, 0);
  endtask

  // Job-level reference: a job is "clear NT words, then per sample: accept, compute
  // for NT+1 cycles, offer result"; positions are tracked as plain counters/ages.
  bit          m_active = 0, m_final = 0, m_start = 0, m_done = 0, m_tl = 0;
  int          m_clr = 0, m_age = -1, m_head = 0;
  logic [31:0] m_len = '0, m_outs = '0;
  int          xs[$];
  int          got_y[$];
  int          clr_q[$];
  int          cyc = 0, t_hs = 0;
  bit          tv_seen = 1;

  // Bench-side BRAMs and accumulator driven by the DUT's addresses and enables
  int mem[NT];
  int acc = 0, tap_do = 0, data_do = 0;

  function automatic int conv(int n);
    int s = 0;
    for (int k = 0; k < NT && k <= n; k++) s += (k + 1) * xs[n - k];
    return s;
  endfunction

  initial for (int i = 0; i < NT; i++) mem[i] = $urandom_range(1, 1000);

  always @(negedge ACLK) begin
    bit in_clr, in_wait, in_mac, in_out, last;
    cyc++;
    if (!ARESET) begin
      chk_reset("rst");
      m_active = 0; m_final = 0; m_start = 0; m_done = 0; m_tl = 0;
      m_clr = 0; m_age = -1; m_head = 0; m_outs = 0; tv_seen = 1;
    end else begin
      in_clr  = m_active && (m_clr < NT);
      in_wait = m_active && !in_clr && (m_age < 0);
      in_mac  = m_active && (m_age >= 1) && (m_age <= NT);
      in_out  = m_active && (m_age >= NT + 2);
      chk("ap_idle", ap_idle, !m_active);
      chk("ap_start", ap_start, m_start);
      chk("ap_done", ap_done, m_done);
      chk("data_en", data_en, m_active || m_final);
      chk("ss_tready", ss_tready, in_wait);
      chk("data_we", data_we, (in_clr || (in_wait && ss_tvalid)) ? 4'hF : 4'h0);
      chk("mac_clr", mac_clr, in_wait && ss_tvalid);
      chk("mac_en", mac_en, m_active && m_age >= 2 && m_age <= NT + 1);
      chk("tap_a", tap_a, in_mac ? 4 * (m_age - 1) : 0);
      chk("sm_tvalid", sm_tvalid, in_out);
      chk("sm_tlast", sm_tlast, in_out && ((m_outs + 32'd1 == m_len) || m_tl));
      if (in_clr) begin
        chk("clr_addr", data_a, 4 * m_clr);
        chk("clr_di_sel", data_di_sel, 0);
      end else if (in_wait) begin
        chk("wr_addr", data_a, 4 * m_head);
        chk("wr_di_sel", data_di_sel, 1);
      end else if (in_mac) begin
        chk("rd_addr", data_a, 4 * ((m_head - (m_age - 1) + NT) % NT));
      end
      if (sm_tvalid && !tv_seen) begin
        chk("latency", cyc - t_hs, 13);
        tv_seen = 1;
      end
      if (data_en && data_we == 4'hF && !data_di_sel) clr_q.push_back(int'(data_a));

      if (!m_active && !m_final) begin
        if (ap_start_set) begin
          m_active = 1; m_clr = 0; m_age = -1; m_head = 0; m_outs = 0; m_len = data_length;
          m_start = 1; m_done = 0; m_tl = 0;
          xs.delete(); got_y.delete(); clr_q.delete();
        end else if (ctrl_read_ack) m_done = 0;
      end else if (m_final) begin
        m_final = 0;
        if (ctrl_read_ack) m_done = 0;
      end else begin
        if (ctrl_read_ack) m_done = 0;
        if (m_clr < NT) begin
          m_clr++;
          if (m_clr == NT && m_len == 0) begin m_active = 0; m_final = 1; m_done = 1; end
        end else if (m_age < 0) begin
          if (ss_tvalid) begin
            m_age = 1; m_start = 0; m_tl = ss_tlast;
            xs.push_back(int'(ss_tdata)); t_hs = cyc; tv_seen = 0;
          end
        end else if (m_age < NT + 2) begin
          m_age++;
        end else if (sm_tready) begin
          chk("y", acc, conv(int'(m_outs)));
          got_y.push_back(acc);
          last = (m_outs + 32'd1 == m_len) || m_tl;
          m_outs++;
          m_head = (m_head + 1) % NT;
          if (last) begin m_active = 0; m_final = 1; m_done = 1; end
          else m_age = -1;
        end
      end

      if (mac_clr) acc = 0;
      else if (mac_en) acc += tap_do * data_do;
      tap_do = (int'(tap_a) / 4 < NT) ? int'(tap_a) / 4 + 1 : 0;
      if (data_en) data_do = (int'(data_a) / 4 < NT) ? mem[int'(data_a) / 4] : 0;
      if (data_en && data_we == 4'hF && int'(data_a) / 4 < NT)
        mem[int'(data_a) / 4] = data_di_sel ? int'(ss_tdata) : 0;
    end
  end

  int samp[64];

  task automatic idle_inputs();
    ap_start_set = 0; ctrl_read_ack = 0; ss_tvalid = 0; ss_tlast = 0; sm_tready = 0;
  endtask

  task automatic run_job(input int len, input int tl_idx, input bit hold5, input bit rnd,
                         input int abort_age);
    int hold_cnt = 0;
    bit held = 0;
    bit aborted = 0;
    int idx;
    @(posedge ACLK); #1;
    data_length = len; ap_start_set = 1;
    @(posedge ACLK); #1;
    ap_start_set = 0;
    for (int c = 0; c < 5000 && (m_active || m_final); c++) begin
      if (abort_age > 0 && m_age == abort_age) begin aborted = 1; break; end
      idx = xs.size();
      ss_tdata  = samp[idx % 64];
      ss_tlast  = (idx == tl_idx);
      ss_tvalid = ($urandom_range(0, 9) < 7);
      if (hold5 && !held && m_active && m_age >= NT + 2) begin hold_cnt = 5; held = 1; end
      if (hold_cnt > 0) begin
        sm_tready = 0;
        ap_start_set = (hold_cnt == 3);
        hold_cnt--;
      end else begin
        sm_tready = ($urandom_range(0, 9) < 6);
        ap_start_set = rnd && ($urandom_range(0, 31) == 0);
      end
      ctrl_read_ack = rnd && ($urandom_range(0, 15) == 0);
      @(posedge ACLK); #1;
    end
    if (aborted) begin
      @(negedge ACLK); #2;
      ARESET = 0;
      idle_inputs();
      #1;
      chk_reset("abort");
      @(negedge ACLK); @(negedge ACLK); #2;
      ARESET = 1;
      @(posedge ACLK); #1;
    end else begin
      chk("job_timeout", m_active || m_final, 0);
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    #22 ARESET = 1;
    @(posedge ACLK); #1;

    // Impulse: outputs are the taps themselves
    samp[0] = 1; samp[1] = 0; samp[2] = 0;
    run_job(3, -1, 0, 0, 0);
    chk("A_nout", got_y.size(), 3);
    for (int i = 0; i < 3 && i < got_y.size(); i++) chk("A_y", got_y[i], i + 1);
    chk("A_nclr", clr_q.size(), 11);
    if (clr_q.size() == 11) begin
      chk("A_clr_first", clr_q[0], 0);
      chk("A_clr_last", clr_q[10], 12'h028);
    end
    chk("A_done_held", ap_done, 1);
    chk("A_idle", ap_idle, 1);
    ctrl_read_ack = 1;
    @(posedge ACLK); #1;
    ctrl_read_ack = 0;
    chk("A_done_clr", ap_done, 0);

    // Step response across the circular-buffer wrap, with output back-pressure
    for (int i = 0; i < 13; i++) samp[i] = 1;
    run_job(13, -1, 1, 0, 0);
    chk("B_nout", got_y.size(), 13);
    for (int i = 0; i < 13 && i < got_y.size(); i++)
      chk("B_y", got_y[i], (i < 11) ? (i + 1) * (i + 2) / 2 : 66);

    // Early tlast on the second sample
    for (int i = 0; i < 5; i++) samp[i] = $urandom_range(0, 255);
    run_job(5, 1, 0, 1, 0);
    chk("C_nout", got_y.size(), 2);

    // Zero-length job
    run_job(0, -1, 0, 0, 0);
    chk("D_nin", xs.size(), 0);
    chk("D_done", ap_done, 1);

    // Reset during MAC cycle 5, then a fresh job
    for (int i = 0; i < 4; i++) samp[i] = $urandom_range(1, 255);
    run_job(4, -1, 0, 0, 5);
    for (int i = 0; i < 4; i++) samp[i] = $urandom_range(0, 255);
    run_job(4, -1, 0, 0, 0);
    chk("E_nout", got_y.size(), 4);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      int len, tl;
      len = $urandom_range(1, 14);
      for (int i = 0; i < 64; i++) samp[i] = $urandom_range(0, 255);
      tl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_job(len, tl, 0, 1, 0);
    end

    repeat (3) @(posedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog at %0t: got running want finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Control sequencer for the FIR engine. It owns the ap_start/ap_done/ap_idle handshake, clears the data BRAM at job start, and accepts one AXI-Stream sample per output. For each sample it generates tap/data BRAM addresses over the circular data buffer plus MAC enables, then presents the result on the output stream. It sits between the AXI-Lite register block, the two BRAMs, the multiply-accumulate datapath and the stream ports.

Parameters:
ADDR_WIDTH, 12, BRAM byte-address width
DATA_WIDTH, 32, data_length width
NUM_TAPS, 11, filter taps = data buffer depth in words

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-low
ap_start_set  in  1  one-cycle pulse: AXI-Lite wrote 1 to bit0 of 0x00
ctrl_read_ack  in  1  one-cycle pulse: AXI-Lite read of 0x00 completed
data_length  in  DATA_WIDTH  samples per job, sampled at start
ap_start  out  1  ap_ctrl bit0
ap_done  out  1  ap_ctrl bit1
ap_idle  out  1  ap_ctrl bit2; also grants tap BRAM to AXI-Lite
ss_tvalid  in  1  input stream valid
ss_tlast  in  1  input stream last
ss_tready  out  1  input stream ready
sm_tvalid  out  1  output stream valid
sm_tready  in  1  output stream ready
sm_tlast  out  1  output stream last
tap_a  out  ADDR_WIDTH  tap BRAM byte address
data_en  out  1  data BRAM enable
data_we  out  4  data BRAM byte write enables
data_a  out  ADDR_WIDTH  data BRAM byte address
data_di_sel  out  1  0: write zero, 1: write ss_tdata
mac_clr  out  1  clear accumulator
mac_en  out  1  accumulate Tap_Do*Data_Do (1-cycle BRAM read latency)

Behaviour:
- Reset (async, ARESET=0): state IDLE; ap_idle=1; ap_start=0; ap_done=0; ss_tready=0; sm_tvalid=0; sm_tlast=0; data_we=0; data_en=0; mac_clr=0; mac_en=0; tap_a=0; data_a=0; head=0; counters=0. Reset mid-job aborts immediately with no further BRAM writes.
- IDLE: on ap_start_set → ap_start=1, ap_idle=0, ap_done=0, latch data_length as len, go to CLR. ap_start_set outside IDLE is ignored.
- CLR: NUM_TAPS cycles; data_a=0,4,…,4*(NUM_TAPS-1); data_we=4'hF; data_di_sel=0; head=0. Then go to DONE if len==0, else to WAIT_IN.
- WAIT_IN: ss_tready=1; data_a=4*head; data_di_sel=1; data_we=4'hF only when ss_tvalid=1.
  - Handshake cycle (cycle 0): sample written, mac_clr=1, ap_start cleared on the first handshake of the job, tlast_seen<=ss_tlast; go to MAC.
- MAC: cycles 1..NUM_TAPS, k=0..NUM_TAPS-1.
  - tap_a=4k; data_a=4*((head-k) mod NUM_TAPS), so tap 0 pairs with the newest sample.
  - mac_en asserted in cycles 2..NUM_TAPS.
- DRAIN: cycle NUM_TAPS+1; mac_en=1 for the last product. Then go to OUT.
- OUT: sm_tvalid=1 from cycle NUM_TAPS+2 (cycle 13 at default), held stable until sm_tready. sm_tlast=1 when out_cnt==len-1 or tlast_seen.
  - On sm_tready: out_cnt++, head=(head+1) mod NUM_TAPS (wrap 4*(NUM_TAPS-1)→0).
  - Go to DONE if that output was last, else to WAIT_IN.
- DONE: one cycle; ap_done=1, ap_idle=1; go to IDLE.
- ap_done stays set until ctrl_read_ack or the next ap_start_set. If ctrl_read_ack coincides with the set, set wins.
- data_en=1 in every state except IDLE. tap_a=0 outside MAC.
- Early ss_tlast: job ends after that sample's output, even if out_cnt<len.
- Input is never accepted while computing; at most one sample is in flight.

Test Plan:
- Reset → ap_idle=1, ap_start=0, ap_done=0, ss_tready=0, sm_tvalid=0; async deassert mid-cycle glitch-free.
- Taps h[k]=k+1, len=3, inputs 1,0,0 → CLR writes 11 zeros at 0x00..0x28; outputs 1,2,3; sm_tlast only on the third; ap_done=1, ap_idle=1; ctrl_read_ack → ap_done=0.
- len=13, all inputs 1 → outputs 1,3,6,…,66,66,66 (wrap check); head returns to 2; handshake-to-sm_tvalid latency = 13 cycles each sample.
- sm_tready low 5 cycles in OUT → sm_tvalid and sm_tlast stable, ss_tready=0; ap_start_set mid-job ignored.
- len=5 with ss_tlast on sample 2 → 2 outputs, second has sm_tlast; len=0 → CLR then DONE, no stream handshakes.
- ARESET low during MAC cycle 5 → all outputs take reset values immediately; new job after release produces correct results from a cleared buffer.
